divsigned_seq: RTL and testbench



---
 rtl/divsigned_seq.sv | 185 ++++++++++++++++++
 tb/tb_divsigned_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/divsigned_seq.sv
// rtl/divsigned_seq.sv - sequential signed divider, one quotient bit per cycle
// Optional feature macro: DIVSIGNED_DBZ_EN (dbz_o port and single-cycle divide-by-zero path).
module divsigned_seq #(
  parameter int IN_SIZE_0 = 4,
  parameter int IN_SIZE_1 = 8,
  localparam int DIV_SIZE = IN_SIZE_0 + IN_SIZE_1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [DIV_SIZE-1:0] in_0_i,
  input  logic [IN_SIZE_1-1:0] in_1_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [DIV_SIZE-1:0] quot_o,
  output logic [DIV_SIZE-1:0] rem_o
`ifdef DIVSIGNED_DBZ_EN
  ,
  output logic                dbz_o
`endif
);

  localparam int CW = $clog2(DIV_SIZE + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state, state_nxt;
  logic                 rdy;
  logic [CW-1:0]        cnt;
  logic [DIV_SIZE-1:0]  dvd;     // dividend magnitude, shifted out MSB first
  logic [DIV_SIZE-1:0]  quo;     // quotient magnitude, shifted in LSB first
  logic [DIV_SIZE-1:0]  rem;     // partial remainder magnitude
  logic [IN_SIZE_1-1:0] dvs;     // divisor magnitude
  logic                 neg_q;
  logic                 neg_r;
  logic                 zdiv;
  logic [DIV_SIZE-1:0]  quot_q;
  logic [DIV_SIZE-1:0]  rem_q;

  logic                 accept;
  logic                 in1_zero;
  logic                 skip_calc;
  logic [DIV_SIZE-1:0]  in0_mag;
  logic [IN_SIZE_1-1:0] in1_mag;
  logic [DIV_SIZE:0]    shifted;
  logic [DIV_SIZE:0]    dvs_ext;
  logic                 ge;
  logic [DIV_SIZE-1:0]  rem_nxt;
  logic [DIV_SIZE-1:0]  quo_fix;
  logic [DIV_SIZE-1:0]  rem_fix;

  // rdy is only ever set while the FSM sits in IDLE, so it alone gates acceptance
  assign accept   = rdy && valid_i;
  assign in1_zero = (in_1_i == '0);

  // Magnitudes fit unsigned in the operand width, including the most negative value
  assign in0_mag = in_0_i[DIV_SIZE-1] ? -in_0_i : in_0_i;
  assign in1_mag = in_1_i[IN_SIZE_1-1] ? -in_1_i : in_1_i;

  // One restoring step: bring in the next dividend bit and trial-subtract the divisor
  assign shifted = {rem, dvd[DIV_SIZE-1]};
  assign dvs_ext = (DIV_SIZE + 1)'(dvs);
  assign ge      = (shifted >= dvs_ext);
  assign rem_nxt = DIV_SIZE'(ge ? (shifted - dvs_ext) : shifted);

  // Sign correction: quotient by XOR of signs, remainder follows the dividend
  assign quo_fix = neg_q ? -quo : quo;
  assign rem_fix = neg_r ? -rem : rem;

`ifdef DIVSIGNED_DBZ_EN
  assign skip_calc = in1_zero;
`else
  assign skip_calc = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = skip_calc ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == CW'(1)) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and result registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdy    <= 1'b0;
      cnt    <= '0;
      dvd    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      zdiv   <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
    end else begin
      rdy <= (state_nxt == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            dvd   <= in0_mag;
            dvs   <= in1_mag;
            rem   <= '0;
            quo   <= '0;
            cnt   <= CW'(DIV_SIZE);
            neg_r <= in_0_i[DIV_SIZE-1];
            neg_q <= in_0_i[DIV_SIZE-1] ^ in_1_i[IN_SIZE_1-1];
            zdiv  <= in1_zero;
`ifdef DIVSIGNED_DBZ_EN
            if (in1_zero) begin
              quot_q <= '1;
              rem_q  <= in_0_i;
            end
`endif
          end
        end
        CALC: begin
          dvd <= {dvd[DIV_SIZE-2:0], 1'b0};
          quo <= {quo[DIV_SIZE-2:0], ge};
          rem <= rem_nxt;
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          // A zero divisor leaves the dividend magnitude in rem, so only the quotient is forced
          quot_q <= zdiv ? '1 : quo_fix;
          rem_q  <= rem_fix;
        end
        default: ;
      endcase
    end
  end

`ifdef DIVSIGNED_DBZ_EN
  logic dbz_q;

  // Divide-by-zero flag, set on the shortcut path and cleared by every normal result
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dbz_q <= 1'b0;
    end else if (state == IDLE && accept && in1_zero) begin
      dbz_q <= 1'b1;
    end else if (state == FIX) begin
      dbz_q <= 1'b0;
    end
  end

  assign dbz_o = dbz_q;
`endif

  assign ready_o = rdy;
  assign valid_o = (state == DONE);
  assign quot_o  = quot_q;
  assign rem_o   = rem_q;

endmodule

// File: tb/tb_divsigned_seq.sv
// tb/tb_divsigned_seq.sv - self-checking bench for divsigned_seq
module tb_divsigned_seq;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [11:0] in_0_i;
  logic [7:0]  in_1_i;
  logic        valid_o;
  logic        ready_i;
  logic [11:0] quot_o;
  logic [11:0] rem_o;
`ifdef DIVSIGNED_DBZ_EN
  logic        dbz_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divsigned_seq dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .in_0_i  (in_0_i),
    .in_1_i  (in_1_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .quot_o  (quot_o),
    .rem_o   (rem_o)
`ifdef DIVSIGNED_DBZ_EN
    ,
    .dbz_o   (dbz_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: C-style truncating division, results wrapped to 12 bits
  function automatic int ref_q(input int a, input int b);
    if (b == 0) return -1;
    return a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    if (b == 0) return a;
    return a % b;
  endfunction

  task automatic start(input int a, input int b);
    int n;
    n = 0;
    while (!ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    in_0_i  = a[11:0];
    in_1_i  = b[7:0];
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!valid_o && lat < 100) begin
      if (ready_o) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (ready_o) busy_ok = 1'b0;
  endtask

  task automatic run_op(input int a, input int b, input int eq, input int er, input string tag);
    int lat;
    int exp_lat;
    bit busy_ok;
    start(a, b);
    wait_valid(lat, busy_ok);
`ifdef DIVSIGNED_DBZ_EN
    exp_lat = (b[7:0] == 8'd0) ? 0 : 13;
`else
    exp_lat = 13;
`endif
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_q"}, 32'(quot_o), 32'(eq[11:0]));
    check({tag, "_r"}, 32'(rem_o), 32'(er[11:0]));
`ifdef DIVSIGNED_DBZ_EN
    check({tag, "_dbz"}, 32'(dbz_o), 32'(b[7:0] == 8'd0));
`endif
    @(posedge clk); #1;
    check({tag, "_vdone"}, 32'(valid_o), 32'd0);
    check({tag, "_rdy"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    logic signed [3:0]  ra;
    logic signed [7:0]  rb;
    logic signed [11:0] rd;
    logic [11:0]        hq;
    logic [11:0]        hr;
    int lat;
    bit busy_ok;

    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    in_0_i  = '0;
    in_1_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_quot", 32'(quot_o), 32'd0);
    check("rst_rem", 32'(rem_o), 32'd0);
`ifdef DIVSIGNED_DBZ_EN
    check("rst_dbz", 32'(dbz_o), 32'd0);
`endif
    rst_ni = 1'b1;
    @(posedge clk); #1;
    check("rel_ready", 32'(ready_o), 32'd1);

    run_op(100, 7, 14, 2, "pp");
    run_op(-100, 7, -14, -2, "np");
    run_op(100, -7, -14, 2, "pn");
    run_op(-100, -7, 14, -2, "nn");
    run_op(-2048, -1, -2048, 0, "ovf");
    run_op(-128, 1, -128, 0, "m128");
    run_op(37, 0, 32'hFFF, 37, "dbz");
    run_op(-5, 0, -1, -5, "dbzn");

    // Back-pressure: result held while ready_i is low; new operands ignored
    ready_i = 1'b0;
    start(100, 7);
    wait_valid(lat, busy_ok);
    check("bp_lat", 32'(lat), 32'd13);
    hq = quot_o;
    hr = rem_o;
    for (int i = 0; i < 5; i++) begin
      in_0_i  = 12'd5;
      in_1_i  = 8'd1;
      valid_i = 1'b1;
      @(posedge clk); #1;
      check("bp_valid", 32'(valid_o), 32'd1);
      check("bp_ready", 32'(ready_o), 32'd0);
      check("bp_quot", 32'(quot_o), 32'(hq));
      check("bp_rem", 32'(rem_o), 32'(hr));
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    check("bp_q", 32'(hq), 32'd14);
    check("bp_r", 32'(hr), 32'd2);
    @(posedge clk); #1;
    check("bp_vdone", 32'(valid_o), 32'd0);
    check("bp_rdy", 32'(ready_o), 32'd1);
    run_op(-100, -7, 14, -2, "post_bp");

    // Reset in the middle of an iteration
    start(100, 7);
    repeat (5) @(posedge clk);
    #1;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_quot", 32'(quot_o), 32'd0);
    check("mid_rst_rem", 32'(rem_o), 32'd0);
    check("mid_rst_ready", 32'(ready_o), 32'd0);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_ready", 32'(ready_o), 32'd1);
    run_op(-100, 7, -14, -2, "post_rst");

    // Round trip: (A*B)/B must give back A exactly
    for (int i = 0; i < 1000; i++) begin
      ra = 4'($urandom);
      do rb = 8'($urandom); while (rb == 8'sd0);
      run_op(int'(ra) * int'(rb), int'(rb), int'(ra), 0, "rt");
    end

    // Arbitrary operands against truncating division
    for (int i = 0; i < 1000; i++) begin
      rd = 12'($urandom);
      rb = 8'($urandom);
      if (i % 97 == 0) rb = 8'sd0;
      run_op(int'(rd), int'(rb), ref_q(int'(rd), int'(rb)), ref_r(int'(rd), int'(rb)), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
